mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
Multi-cycle multiply/divide sequencer for the MIPS core. It computes MULTU/DIVU into HI/LO by time-sharing the external combinational 32-bit ALU (opcodes: 0 AND, 1 OR, 2 ADD, 3 XOR; carry-in/carry-out), one add or subtract per cycle. The decoder drives it with a start/busy/done handshake. HI/LO feed mfhi/mflo.

Parameters:
- ITER, 32, iterations per operation; fixed to the datapath width.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset
- start  in  1  request; sampled only when busy=0
- op  in  2  bit0: 0 multiply / 1 divide; bit1: signed (see Optional Feature)
- opa  in  32  multiplicand / dividend; sampled with start
- opb  in  32  multiplier / divisor; sampled with start
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; hi/lo valid
- hi  out  32  product[63:32] / remainder
- lo  out  32  product[31:0] / quotient
- alu_a, alu_b  out  32  ALU operands
- alu_cin  out  1  ALU carry-in
- alu_op  out  2  ALU opcode
- alu_result  in  32  ALU result, same cycle
- alu_cout  in  1  ALU carry-out, same cycle

Behaviour:
- Interface: one clock (clk); rst is synchronous, active-high.
- Reset: state IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
- Mid-operation reset: the operation is abandoned silently and no done is produced.
- ALU outputs in IDLE/DONE: alu_a=0, alu_b=0, alu_cin=0, alu_op=0.
- States: IDLE, MUL, DIV, DONE (plus PRE/POST with the optional feature).
- Start acceptance:
  - start is accepted in IDLE or DONE, so back-to-back operations work.
  - start is ignored in MUL/DIV; operands are not re-sampled.
- busy is high in MUL/DIV/PRE/POST; done is high only in DONE.
- Latency: start high in cycle N -> busy in N+1..N+32 -> done in N+33. DONE lasts one cycle, then IDLE unless a new start is accepted.
- MUL (hi=0, lo=opb, mcand=opa):
  - Each cycle: alu_op=ADD, alu_a=hi, alu_b = lo[0] ? mcand : 0, alu_cin=0.
  - Then {hi,lo} <= {alu_cout, alu_result, lo[31:1]}.
- DIV (hi=0, lo=opa, dvsr=opb), restoring:
  - r = {hi[30:0], lo[31]}.
  - alu_op=ADD, alu_a=r, alu_b=~dvsr, alu_cin=1.
  - take = hi[31] | alu_cout.
  - hi <= take ? alu_result : r; lo <= {lo[30:0], take}.
- Divide by zero (op divide, opb=0): IDLE -> DONE directly; done in N+1; hi=opa, lo=32'hFFFFFFFF.
- Counter: 5-bit, counts 0..31; leaves MUL/DIV when the counter is 31; wrap is not observable.
- hi/lo: working registers. Undefined while busy; hold the final result from done until the next accepted start.

Optional Feature:
- Macro: MDU_SIGNED_EN.
- Enabled: op[1]=1 selects signed MULT/DIV.
  - PRE, 2 cycles: replace each negative operand by its magnitude. ALU does ADD with alu_a=~x, alu_b=0, alu_cin=1; one operand per cycle.
  - Then 32 unsigned iterations.
  - POST, 2 cycles: conditional negation of the results.
    - Multiply: lo first (capture carry), then hi with alu_a=~hi, alu_cin=saved carry.
    - Divide: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - Fixed latency: done in N+37. Divide by zero still gives done in N+1 with raw operands.
- Disabled: op[1] is ignored and treated as unsigned; no PRE/POST states.

Decomposition:
- Package mdu_pkg holds:
  - ALU opcode constants: ALU_AND=2'd0, ALU_OR=2'd1, ALU_ADD=2'd2, ALU_XOR=2'd3.
  - op bit positions.
  - State encoding.
  - ITER.
- Sub-module mdu_sign_fix (only under MDU_SIGNED_EN): sign capture plus PRE/POST operand muxing.
- The ALU stays external and shared; the top level muxes ALU inputs between the core datapath and mdu_seq using busy.

Test Plan:
- MULTU opa=7, opb=6 -> done at N+33, hi=0, lo=42; busy high for exactly 32 cycles.
- MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001 (carry-out path).
- DIVU 100/7 -> lo=14, hi=2. Then DIVU 5/0 -> done at N+1, hi=5, lo=32'hFFFFFFFF.
- start pulsed at N+10 with different operands during a busy MULTU 7x6 -> ignored; result still 42. A start in the DONE cycle launches a new operation with done 33 cycles later.
- rst asserted at N+15 -> next cycle busy=0, done=0, hi=lo=0; no done pulse follows.
- MDU_SIGNED_EN:
  - MULT -7 x 3 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB at N+37.
  - DIV -7/2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
  - Without the macro, op=2'b10 with 7x6 -> 42 at N+33.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   - ALU opcode constants for the external shared 32-bit ALU
//   - bit positions inside the 2-bit op field
//   - sequencer state encoding and iteration count
package mdu_pkg;

  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = $clog2(ITER);

  localparam logic [1:0] ALU_AND = 2'd0;
  localparam logic [1:0] ALU_OR  = 2'd1;
  localparam logic [1:0] ALU_ADD = 2'd2;
  localparam logic [1:0] ALU_XOR = 2'd3;

  localparam int unsigned OP_DIV    = 0;
  localparam int unsigned OP_SIGNED = 1;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StDiv,
    StDone,
    StPre,
    StPost
  } state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Sign handling for signed MULT/DIV (used only when MDU_SIGNED_EN is defined).
// Captures operand signs at start, then supplies the ALU operand and carry-in
// for the two magnitude cycles before the iterations and the two conditional
// negation cycles after them. The ALU always runs ADD with alu_b = 0 here, so
// a negation is ~x + 1 and a pass-through is x + 0.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   capture             start accepted this cycle
//   signed_in           op requests signed arithmetic
//   opa_sign, opb_sign  operand sign bits at start
//   div                 current operation is a divide
//   in_pre, in_post     sequencer is in the pre / post phase
//   step                0 = first, 1 = second cycle of the phase
//   hi, lo, mreg        sequencer working registers
//   alu_cout            ALU carry-out
//   signed_op           captured signed flag
//   fix_a, fix_cin      ALU operand A and carry-in for pre/post cycles
module mdu_sign_fix (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic        signed_in,
  input  logic        opa_sign,
  input  logic        opb_sign,
  input  logic        div,
  input  logic        in_pre,
  input  logic        in_post,
  input  logic        step,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic [31:0] mreg,
  input  logic        alu_cout,
  output logic        signed_op,
  output logic [31:0] fix_a,
  output logic        fix_cin
);

  logic        active_q, sa_q, sb_q, carry_q;
  logic [31:0] x;
  logic        neg, cin_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      if (capture) begin
        active_q <= signed_in;
        sa_q     <= opa_sign;
        sb_q     <= opb_sign;
      end
      // Carry out of the low-word negation feeds the high-word negation.
      if (in_post && !step) carry_q <= alu_cout;
    end
  end

  // lo holds the dividend for divide but the multiplier for multiply, and
  // mreg holds the other operand; pick the matching sign for each.
  always_comb begin
    x       = lo;
    neg     = 1'b0;
    cin_sel = 1'b1;
    if (in_pre) begin
      if (!step) begin
        x   = lo;
        neg = div ? sa_q : sb_q;
      end else begin
        x   = mreg;
        neg = div ? sb_q : sa_q;
      end
    end else if (in_post) begin
      if (!step) begin
        x   = lo;
        neg = sa_q ^ sb_q;
      end else begin
        x       = hi;
        neg     = div ? sa_q : (sa_q ^ sb_q);
        cin_sel = div ? 1'b1 : carry_q;
      end
    end
    fix_a   = neg ? ~x : x;
    fix_cin = neg & cin_sel;
  end

  assign signed_op = active_q;

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle MULTU/DIVU sequencer writing HI/LO. Time-shares the external
// combinational ALU: one shift-add (multiply) or restoring compare-subtract
// (divide) step per cycle for ITER cycles. Divide by zero finishes at once
// with hi = dividend, lo = all ones.
// Optional signed MULT/DIV: define MDU_SIGNED_EN (adds pre/post sign cycles).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, op, opa, opb  request, op (bit0 divide, bit1 signed), operands
//   busy, done           operation in progress / one-cycle result pulse
//   hi, lo               product high/low or remainder/quotient
//   alu_a, alu_b, alu_cin, alu_op   drive to the shared ALU
//   alu_result, alu_cout            same-cycle ALU response
module mdu_seq
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_cin,
  output logic [1:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_cout
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        m_q, m_d;   // multiplicand or divisor
  logic               div_q, div_d;
  logic               accept, is_signed, signed_op, last_iter, take;
  logic [31:0]        rem_sh;

`ifdef MDU_SIGNED_EN
  logic [31:0] fix_a;
  logic        fix_cin;

  assign is_signed = op[OP_SIGNED];

  mdu_sign_fix u_sign_fix (
    .clk       (clk),
    .rst       (rst),
    .capture   (accept),
    .signed_in (op[OP_SIGNED]),
    .opa_sign  (opa[31]),
    .opb_sign  (opb[31]),
    .div       (div_q),
    .in_pre    (state_q == StPre),
    .in_post   (state_q == StPost),
    .step      (cnt_q[0]),
    .hi        (hi_q),
    .lo        (lo_q),
    .mreg      (m_q),
    .alu_cout  (alu_cout),
    .signed_op (signed_op),
    .fix_a     (fix_a),
    .fix_cin   (fix_cin)
  );
`else
  logic unused_op_signed;
  assign unused_op_signed = op[OP_SIGNED];
  assign is_signed        = 1'b0;
  assign signed_op        = 1'b0;
`endif

  assign accept    = start && (state_q == StIdle || state_q == StDone);
  assign last_iter = (cnt_q == CNT_W'(ITER - 1));
  // Partial remainder shifted left; hi[31] acts as its 33rd bit.
  assign rem_sh    = {hi_q[30:0], lo_q[31]};
  assign take      = hi_q[31] | alu_cout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
      div_q   <= div_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = m_q;
    div_d   = div_q;
    alu_a   = '0;
    alu_b   = '0;
    alu_cin = 1'b0;
    alu_op  = ALU_AND;

    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          div_d = op[OP_DIV];
          cnt_d = '0;
          if (op[OP_DIV] && opb == '0) begin
            state_d = StDone;
            hi_d    = opa;
            lo_d    = '1;
          end else begin
            hi_d    = '0;
            lo_d    = op[OP_DIV] ? opa : opb;
            m_d     = op[OP_DIV] ? opb : opa;
            if (is_signed)       state_d = StPre;
            else if (op[OP_DIV]) state_d = StDiv;
            else                 state_d = StMul;
          end
        end
      end

      StMul: begin
        alu_op         = ALU_ADD;
        alu_a          = hi_q;
        alu_b          = lo_q[0] ? m_q : '0;
        {hi_d, lo_d}   = {alu_cout, alu_result, lo_q[31:1]};
        cnt_d          = cnt_q + 1'b1;
        if (last_iter) state_d = signed_op ? StPost : StDone;
      end

      StDiv: begin
        alu_op         = ALU_ADD;
        alu_a          = rem_sh;
        alu_b          = ~m_q;
        alu_cin        = 1'b1;
        hi_d           = take ? alu_result : rem_sh;
        lo_d           = {lo_q[30:0], take};
        cnt_d          = cnt_q + 1'b1;
        if (last_iter) state_d = signed_op ? StPost : StDone;
      end

`ifdef MDU_SIGNED_EN
      StPre: begin
        alu_op  = ALU_ADD;
        alu_a   = fix_a;
        alu_cin = fix_cin;
        if (!cnt_q[0]) begin
          lo_d  = alu_result;
          cnt_d = cnt_q + 1'b1;
        end else begin
          m_d     = alu_result;
          cnt_d   = '0;
          state_d = div_q ? StDiv : StMul;
        end
      end

      StPost: begin
        alu_op  = ALU_ADD;
        alu_a   = fix_a;
        alu_cin = fix_cin;
        if (!cnt_q[0]) begin
          lo_d  = alu_result;
          cnt_d = cnt_q + 1'b1;
        end else begin
          hi_d    = alu_result;
          cnt_d   = '0;
          state_d = StDone;
        end
      end
`endif

      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q == StMul) || (state_q == StDiv) ||
                (state_q == StPre) || (state_q == StPost);
  assign done = (state_q == StDone);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: external ALU model, arithmetic reference
// model of results and timing, per-cycle compare, directed and random stimulus.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  op;
  logic [31:0] opa, opb;
  logic        busy, done;
  logic [31:0] hi, lo, alu_a, alu_b, alu_result;
  logic        alu_cin, alu_cout;
  logic [1:0]  alu_op;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  mdu_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .opa        (opa),
    .opb        (opb),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_cout   (alu_cout)
  );

  // External combinational ALU.
  always_comb begin
    alu_result = '0;
    alu_cout   = 1'b0;
    case (alu_op)
      2'd0: alu_result = alu_a & alu_b;
      2'd1: alu_result = alu_a | alu_b;
      2'd2: {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + 33'(alu_cin);
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference result and latency (start cycle to done cycle).
  task automatic model_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rh, output logic [31:0] rl, output int lat);
    logic [63:0] p;
    logic [31:0] ma, mb, q, r;
    logic        sgn;
`ifdef MDU_SIGNED_EN
    sgn = o[1];
`else
    sgn = 1'b0;
`endif
    if (o[0] && b == 0) begin
      rh = a; rl = 32'hFFFFFFFF; lat = 1;
    end else begin
      ma  = (sgn && a[31]) ? -a : a;
      mb  = (sgn && b[31]) ? -b : b;
      lat = sgn ? 37 : 33;
      if (!o[0]) begin
        p = {32'd0, ma} * {32'd0, mb};
        if (sgn && (a[31] ^ b[31])) p = -p;
        rh = p[63:32]; rl = p[31:0];
      end else begin
        q = ma / mb; r = ma % mb;
        if (sgn && (a[31] ^ b[31])) q = -q;
        if (sgn && a[31]) r = -r;
        rh = r; rl = q;
      end
    end
  endtask

  // Model state: busy cycles left, done flag, whether hi/lo are defined.
  int unsigned bl = 0;
  logic        dn = 1'b0, vh = 1'b0, model_ok = 1'b0;
  logic [31:0] eh = '0, el = '0;

  always @(posedge clk) begin
    int lat;
    cyc++;
    if (rst) begin
      bl = 0; dn = 1'b0; vh = 1'b1; eh = '0; el = '0; model_ok = 1'b1;
    end else if (model_ok) begin
      if (bl == 0 && start) begin
        model_op(op, opa, opb, eh, el, lat);
        bl = lat - 1;
        dn = (lat == 1);
        vh = dn;
      end else if (bl > 0) begin
        bl--;
        dn = (bl == 0);
        if (dn) vh = 1'b1;
      end else begin
        dn = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("busy", 32'(busy), 32'(bl > 0));
      chk("done", 32'(done), 32'(dn));
      if (vh) begin
        chk("hi", hi, eh);
        chk("lo", lo, el);
      end
      if (bl == 0) begin
        chk("alu_idle", {alu_a | alu_b}, 32'd0);
        chk("alu_ctl_idle", {29'd0, alu_op, alu_cin}, 32'd0);
      end
    end
  end

  task automatic launch_now(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; opa = a; opb = b;
  endtask

  // Waits (bounded) for done; optionally pokes a start while busy.
  task automatic wait_done(input int poke, output int lat, output int nbusy);
    lat = 0; nbusy = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (poke > 0 && k == poke) begin start = 1'b1; op = 2'b01; opa = 32'd9; opb = 32'd9; end
      if (poke > 0 && k == poke + 1) start = 1'b0;
      if (busy) nbusy++;
      if (done) begin lat = k; break; end
    end
  endtask

  task automatic run(input string name, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input int poke, input int elat,
                     input logic [31:0] ehi, input logic [31:0] elo, output int nbusy);
    int lat;
    launch_now(o, a, b);
    wait_done(poke, lat, nbusy);
    chk({name, "_lat"}, 32'(lat), 32'(elat));
    chk({name, "_hi"}, hi, ehi);
    chk({name, "_lo"}, lo, elo);
  endtask

  function automatic logic [31:0] rand_val();
    int unsigned s = $urandom_range(7);
    if (s == 0) return 32'd0;
    if (s < 3)  return 32'($urandom_range(20));
    if (s == 3) return 32'hFFFFFFFF - 32'($urandom_range(3));
    return $urandom;
  endfunction

  initial begin
    int nb, lat;
    logic saw;
    rst = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hilo", hi | lo, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run("mul7x6", 2'b00, 32'd7, 32'd6, 0, 33, 32'd0, 32'd42, nb);
    chk("mul7x6_busy_cycles", 32'(nb), 32'd32);
    @(negedge clk);
    run("mul_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 33, 32'hFFFFFFFE, 32'h1, nb);
    @(negedge clk);
    run("div100_7", 2'b01, 32'd100, 32'd7, 0, 33, 32'd2, 32'd14, nb);
    // Back-to-back from the DONE cycle.
    run("div5_0", 2'b01, 32'd5, 32'd0, 0, 1, 32'd5, 32'hFFFFFFFF, nb);
    chk("div5_0_busy_cycles", 32'(nb), 32'd0);
    @(negedge clk);
    run("mul_poke", 2'b00, 32'd7, 32'd6, 10, 33, 32'd0, 32'd42, nb);
    run("mul_b2b", 2'b00, 32'd3, 32'd5, 0, 33, 32'd0, 32'd15, nb);
`ifdef MDU_SIGNED_EN
    @(negedge clk);
    run("smul", 2'b10, -32'd7, 32'd3, 0, 37, 32'hFFFFFFFF, 32'hFFFFFFEB, nb);
    @(negedge clk);
    run("sdiv", 2'b11, -32'd7, 32'd2, 0, 37, 32'hFFFFFFFF, 32'hFFFFFFFD, nb);
    @(negedge clk);
    run("sdiv0", 2'b11, -32'd7, 32'd0, 0, 1, -32'd7, 32'hFFFFFFFF, nb);
`else
    @(negedge clk);
    run("op10_unsigned", 2'b10, 32'd7, 32'd6, 0, 33, 32'd0, 32'd42, nb);
`endif

    // Reset in the middle of an operation.
    @(negedge clk);
    launch_now(2'b00, 32'd7, 32'd6);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_hilo", hi | lo, 32'd0);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    chk("midrst_no_done", 32'(saw), 32'd0);

    // Random traffic, including starts while busy and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst   = ($urandom_range(599) == 0);
      start = ($urandom_range(4) == 0);
      op    = 2'($urandom);
      opa   = rand_val();
      opb   = rand_val();
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    lat = 0;
    repeat (45) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
